// File: rtl/bit_8_if.sv
// Request/response bundle for the bit_8 sequential signed multiplier.
// The master drives operands and start; the slave returns busy, done and Product.
interface bit_8_if;
  logic        start;
  logic [8:0]  Data_A;
  logic [8:0]  Data_B;
  logic        busy;
  logic        done;
  logic [17:0] Product;

  modport master (
    output start,
    output Data_A,
    output Data_B,
    input  busy,
    input  done,
    input  Product
  );

  modport slave (
    input  start,
    input  Data_A,
    input  Data_B,
    output busy,
    output done,
    output Product
  );
endinterface

// File: rtl/bit_8.sv
// Sequential radix-2 Booth multiplier: 9x9 signed operands, 18-bit signed product.
// One product every 11 cycles; a new start is taken in DONE so results can run back-to-back.
module bit_8 (
   input logic   clk,
   input logic   rst_n,
   bit_8_if.slave bus
);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone
   } state_e;

   state_e      state_q;
   logic [8:0]  mcand_q;
   logic [9:0]  acc_q;
   logic [8:0]  mplier_q;
   logic        q_m1_q;
   logic [3:0]  cnt_q;
   logic        busy_q;
   logic        done_q;
   logic [17:0] product_q;

   logic        accept;
   logic [9:0]  mcand_ext;
   logic [9:0]  sum;
   logic [9:0]  step_acc;
   logic [8:0]  step_mplier;
   logic        step_q_m1;

   // IDLE and DONE both return to IDLE on the next edge, so both may take a new request.
   assign accept = bus.start && ((state_q == StIdle) || (state_q == StDone));

   // Ten-bit accumulator so that subtracting -256 cannot wrap.
   always_comb begin
      mcand_ext = {mcand_q[8], mcand_q};
      sum       = acc_q;
      case ({mplier_q[0], q_m1_q})
         2'b01:   sum = acc_q + mcand_ext;
         2'b10:   sum = acc_q - mcand_ext;
         default: sum = acc_q;
      endcase
      step_acc    = {sum[9], sum[9:1]};
      step_mplier = {sum[0], mplier_q[8:1]};
      step_q_m1   = mplier_q[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mcand_q   <= '0;
         acc_q     <= '0;
         mplier_q  <= '0;
         q_m1_q    <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (accept) begin
            mcand_q  <= bus.Data_A;
            mplier_q <= bus.Data_B;
            acc_q    <= '0;
            q_m1_q   <= 1'b0;
            cnt_q    <= 4'd9;
            busy_q   <= 1'b1;
            state_q  <= StRun;
         end else begin
            case (state_q)
               StIdle: begin
                  busy_q <= 1'b0;
               end
               StRun: begin
                  if (cnt_q != 4'd0) begin
                     acc_q    <= step_acc;
                     mplier_q <= step_mplier;
                     q_m1_q   <= step_q_m1;
                     cnt_q    <= cnt_q - 4'd1;
                  end else begin
                     // The 19-bit {acc, mplier} result always fits 18 signed bits.
                     product_q <= {acc_q[8:0], mplier_q};
                     done_q    <= 1'b1;
                     state_q   <= StDone;
                  end
               end
               StDone: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
               default: begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.Product = product_q;

   a_done_implies_busy: assert property (@(posedge clk) disable iff (!rst_n) done_q |-> busy_q);
   a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
      busy_q == (state_q != StIdle));

endmodule

// File: tb/tb_bit_8.sv
// Self-checking bench for bit_8: cycle-level behavioural model plus directed literal cases
// and a randomized start/operand stream.
module tb_bit_8;

   logic clk = 1'b0;
   logic rst_n;
   bit   check_en = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   bit_8_if bus ();

   bit_8 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] mul9(input logic [8:0] a, input logic [8:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[17:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: m_age counts edges since the accepting edge; the result appears 10 edges later
   // (age 11), that cycle is DONE, and a request is accepted when idle or in DONE.
   int          m_age;
   logic [8:0]  m_a, m_b;
   logic [17:0] m_prod;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_age  <= 0;
         m_prod <= '0;
         m_a    <= '0;
         m_b    <= '0;
      end else begin
         if (bus.start && (m_age == 0 || m_age == 11)) begin
            m_age <= 1;
            m_a   <= bus.Data_A;
            m_b   <= bus.Data_B;
         end else if (m_age == 11) begin
            m_age <= 0;
         end else if (m_age != 0) begin
            m_age <= m_age + 1;
         end
         if (m_age == 10) m_prod <= mul9(m_a, m_b);
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("model busy", bus.busy, (m_age != 0));
         check("model done", bus.done, (m_age == 11));
         check("model product", bus.Product, m_prod);
      end
   end

   task automatic run_op(input logic [8:0] a, input logic [8:0] b, input logic [17:0] exp,
                         input string name);
      int cyc;
      bus.Data_A = a;
      bus.Data_B = b;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
      end
      check({name, " latency"}, cyc, 10);
      check({name, " product"}, bus.Product, exp);
      @(posedge clk);
      #1;
      check({name, " done single"}, bus.done, 1'b0);
      check({name, " idle busy"}, bus.busy, 1'b0);
   endtask

   initial begin
      int          dones;
      int          cyc;
      logic [17:0] got;
      logic [8:0]  corners [5];
      corners[0] = 9'h100;
      corners[1] = 9'h0FF;
      corners[2] = 9'h000;
      corners[3] = 9'h1FF;
      corners[4] = 9'h001;

      rst_n      = 1'b0;
      bus.start  = 1'b0;
      bus.Data_A = '0;
      bus.Data_B = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", bus.busy, 1'b0);
      check("reset done", bus.done, 1'b0);
      check("reset product", bus.Product, 18'h0);
      #2 rst_n = 1'b1;
      check_en = 1'b1;
      @(posedge clk);
      #1;

      run_op(9'd183, -9'sd99, 18'h3B93B, "183x-99");
      run_op(9'h100, 9'h100, 18'h10000, "-256x-256");
      run_op(9'd255, 9'd255, 18'h0FE01, "255x255");
      run_op(9'h100, 9'd255, 18'h30100, "-256x255");
      run_op(9'd0, -9'sd99, 18'h00000, "0x-99");

      // Operands and start changing mid-operation must not disturb the captured request.
      bus.Data_A = 9'd183;
      bus.Data_B = -9'sd99;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bus.Data_A = 9'd1;
      bus.Data_B = 9'd1;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      dones = 0;
      got   = '0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.done) begin
            dones++;
            got = bus.Product;
         end
      end
      check("ignored start done count", dones, 1);
      check("ignored start product", got, 18'h3B93B);

      // Reset mid-operation aborts without a result.
      bus.Data_A = 9'd100;
      bus.Data_B = 9'd100;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", bus.busy, 1'b0);
      check("abort done", bus.done, 1'b0);
      check("abort product", bus.Product, 18'h0);
      #2 rst_n = 1'b1;
      dones = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.done) dones++;
      end
      check("abort no done", dones, 0);
      check("abort product held", bus.Product, 18'h0);

      // Back-to-back: second start presented on the DONE cycle.
      bus.Data_A = 9'd3;
      bus.Data_B = -9'sd5;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 0;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("b2b first product", bus.Product, 18'h3FFF1);
      bus.Data_A = -9'sd7;
      bus.Data_B = 9'd7;
      bus.start  = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc = 1;
      while (!bus.done && cyc < 20) begin
         @(posedge clk);
         #1 cyc++;
      end
      check("b2b done spacing", cyc, 11);
      check("b2b second product", bus.Product, 18'h3FFCF);
      repeat (2) @(posedge clk);
      #1;

      // Random request stream, including starts while busy and corner operands.
      repeat (700) begin
         bus.start  = ($urandom_range(0, 2) == 0);
         bus.Data_A = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)]
                                                  : 9'($urandom);
         bus.Data_B = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)]
                                                  : 9'($urandom);
         @(posedge clk);
         #1;
      end
      bus.start = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      check_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
